simon_tone_sequencer: RTL and testbench

Plays a stored Simon pattern through the sound controller. It drives the one-hot `led_color` bus, which the sound controller turns into tone and frequency, one step at a time with fixed tone and gap durations. It reads colour codes from the pattern memory and reports busy and done to the game FSM. It also arbitrates `led_color` between pattern playback and live player-button echo. Playback always wins.

---
 rtl/simon_pkg.sv | 42 ++++
 rtl/duration_timer.sv | 28 ++
 rtl/simon_tone_sequencer.sv | 136 +++++++++++++
 tb/tb_simon_tone_sequencer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// Shared types and helpers for the Simon tone path: colour codes, sequencer
// states and the default tone/gap durations used by the sound controller tests.
package simon_pkg;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        BLUE   = 2'd1,
        GREEN  = 2'd2,
        YELLOW = 2'd3
    } color_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        TONE  = 3'd3,
        GAP   = 3'd4,
        DONE  = 3'd5
    } seq_state_e;

    localparam int DEFAULT_MAX_LEN     = 32;
    localparam int DEFAULT_TONE_CYCLES = 25_000_000;
    localparam int DEFAULT_GAP_CYCLES  = 12_500_000;

    function automatic logic [3:0] color_to_onehot(input color_e c);
        logic [3:0] oh;
        oh = 4'b0000;
        case (c)
            RED:     oh = 4'b0001;
            BLUE:    oh = 4'b0010;
            GREEN:   oh = 4'b0100;
            YELLOW:  oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

endpackage

// File: rtl/duration_timer.sv
// Down-counter for fixed-length phases: load N-1 on phase entry, expire pulses
// on the last cycle of the phase while enabled.
module duration_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             expire
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign expire = en && (cnt == '0);

endmodule

// File: rtl/simon_tone_sequencer.sv
// Plays a stored Simon pattern onto led_color (tone then gap per step) and
// echoes single player presses while idle; playback owns led_color when busy.
module simon_tone_sequencer
    import simon_pkg::*;
#(
    parameter int MAX_LEN     = DEFAULT_MAX_LEN,
    parameter int TONE_CYCLES = DEFAULT_TONE_CYCLES,
    parameter int GAP_CYCLES  = DEFAULT_GAP_CYCLES,
    parameter int ADDR_W      = $clog2(MAX_LEN),
    parameter int LEN_W       = $clog2(MAX_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [LEN_W-1:0]  seq_len,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [1:0]        rd_data,
    input  logic              player_en,
    input  logic [3:0]        player_press,
    output logic [3:0]        led_color,
    output logic              busy,
    output logic              done
);

    localparam int MAX_DUR = (TONE_CYCLES > GAP_CYCLES) ? TONE_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(MAX_DUR + 1);

    seq_state_e        state, state_n;
    logic [ADDR_W-1:0] step, step_n;
    logic [LEN_W-1:0]  len, len_n;
    logic [3:0]        led_n;
    logic              tmr_load, tmr_en, tmr_expire;
    logic [CNT_W-1:0]  tmr_val;

    duration_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .expire   (tmr_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            step      <= '0;
            len       <= '0;
            led_color <= 4'b0000;
        end else begin
            state     <= state_n;
            step      <= step_n;
            len       <= len_n;
            led_color <= led_n;
        end
    end

    always_comb begin
        state_n  = state;
        step_n   = step;
        len_n    = len;
        led_n    = led_color;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        tmr_val  = '0;

        case (state)
            IDLE: begin
                led_n = (player_en && is_onehot4(player_press)) ? player_press : 4'b0000;
                if (start && !abort) begin
                    step_n = '0;
                    if (seq_len == '0) begin
                        state_n = DONE;
                    end else begin
                        len_n   = (seq_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : seq_len;
                        state_n = FETCH;
                    end
                end
            end
            FETCH: begin
                led_n   = 4'b0000;
                state_n = LOAD;
            end
            LOAD: begin
                // rd_data now reflects the address presented during FETCH
                led_n    = color_to_onehot(color_e'(rd_data));
                tmr_load = 1'b1;
                tmr_val  = CNT_W'(TONE_CYCLES - 1);
                state_n  = TONE;
            end
            TONE: begin
                tmr_en = 1'b1;
                if (tmr_expire) begin
                    led_n    = 4'b0000;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(GAP_CYCLES - 1);
                    state_n  = GAP;
                end
            end
            GAP: begin
                tmr_en = 1'b1;
                if (tmr_expire) begin
                    if (LEN_W'(step) == (len - LEN_W'(1))) begin
                        state_n = DONE;
                    end else begin
                        step_n  = step + ADDR_W'(1);
                        state_n = FETCH;
                    end
                end
            end
            DONE: begin
                led_n   = 4'b0000;
                state_n = IDLE;
            end
            default: begin
                led_n   = 4'b0000;
                state_n = IDLE;
            end
        endcase

        if (abort && (state != IDLE)) begin
            state_n  = IDLE;
            led_n    = 4'b0000;
            tmr_load = 1'b0;
            tmr_en   = 1'b0;
        end
    end

    assign rd_addr = step;
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);

endmodule

// File: tb/tb_simon_tone_sequencer.sv
// Randomized bench for simon_tone_sequencer: expected outputs come from the
// step-timeline arithmetic (period, tone window, done offset) and echo rules.
module tb_simon_tone_sequencer;

    localparam int MAX_LEN = 8;
    localparam int TONE    = 4;
    localparam int GAP     = 2;
    localparam int ADDR_W  = 3;
    localparam int LEN_W   = 4;
    localparam int PERIOD  = 2 + TONE + GAP;

    logic              clk = 1'b0;
    logic              rst, start, abort;
    logic [LEN_W-1:0]  seq_len;
    logic [ADDR_W-1:0] rd_addr;
    logic [1:0]        rd_data = 2'd0;
    logic              player_en;
    logic [3:0]        player_press, led_color;
    logic              busy, done;

    logic [1:0] mem [MAX_LEN];
    int n_checks = 0;
    int n_errs   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) rd_data <= mem[rd_addr];

    simon_tone_sequencer #(
        .MAX_LEN     (MAX_LEN),
        .TONE_CYCLES (TONE),
        .GAP_CYCLES  (GAP),
        .ADDR_W      (ADDR_W),
        .LEN_W       (LEN_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .seq_len      (seq_len),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .player_en    (player_en),
        .player_press (player_press),
        .led_color    (led_color),
        .busy         (busy),
        .done         (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [3:0] echo_of(input logic en, input logic [3:0] p);
        return (en && ($countones(p) == 1)) ? p : 4'b0000;
    endfunction

    function automatic logic [3:0] rand_press();
        logic [3:0] p;
        if ($urandom_range(0, 1) == 1) p = 4'b0001 << $urandom_range(0, 3);
        else                           p = 4'($urandom);
        return p;
    endfunction

    // Start a play at the next negedge (cycle T) and check every cycle T+1..end.
    task automatic play(input int req, input int abort_at, input bit restart4, input bit noisy);
        int eff, doneoff, last, k, ph;
        bit aborted;
        logic [3:0] e_led, first_echo;
        logic e_busy, e_done;
        eff     = (req > MAX_LEN) ? MAX_LEN : req;
        doneoff = (eff == 0) ? 1 : eff * PERIOD + 1;
        last    = (abort_at > 0 && abort_at < doneoff) ? abort_at + 1 : doneoff + 1;
        @(negedge clk);
        start   = 1'b1;
        abort   = 1'b0;
        seq_len = req[LEN_W-1:0];
        if (noisy) begin
            player_en    = 1'($urandom);
            player_press = rand_press();
        end
        first_echo = echo_of(player_en, player_press);
        for (int i = 1; i <= last; i++) begin
            @(negedge clk);
            aborted = (abort_at > 0) && (abort_at < doneoff) && (i > abort_at);
            k  = (i - 1) / PERIOD;
            ph = (i - 1) % PERIOD;
            if (aborted) begin
                e_led = 4'b0000; e_busy = 1'b0; e_done = 1'b0;
            end else begin
                e_busy = (i <= doneoff);
                e_done = (i == doneoff);
                if (i == 1)
                    e_led = first_echo;
                else if (k < eff && ph >= 2 && ph < 2 + TONE)
                    e_led = 4'b0001 << mem[k];
                else
                    e_led = 4'b0000;
            end
            chk("led", led_color, e_led);
            chk("busy", busy, e_busy);
            chk("done", done, e_done);
            if (!aborted && e_busy && k < eff) chk("rd_addr", rd_addr, k);
            start   = restart4 && (i == 4);
            seq_len = LEN_W'($urandom);
            abort   = (i == abort_at);
            if (noisy) begin
                player_en    = 1'($urandom);
                player_press = rand_press();
            end
        end
        start     = 1'b0;
        abort     = 1'b0;
        player_en = 1'b0;
    endtask

    task automatic echo_one(input logic en, input logic [3:0] p);
        @(negedge clk);
        player_en    = en;
        player_press = p;
        @(negedge clk);
        chk("echo", led_color, echo_of(en, p));
        chk("echo_busy", busy, 1'b0);
    endtask

    task automatic reset_mid_play();
        bit seen_done = 1'b0;
        @(negedge clk);
        start = 1'b1; seq_len = 4'd3;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("rst_led", led_color, 4'b0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_addr", rd_addr, 0);
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done || busy) seen_done = 1'b1;
        end
        chk("rst_no_resume", seen_done, 1'b0);
    endtask

    task automatic start_with_abort_idle();
        @(negedge clk);
        start = 1'b1; abort = 1'b1; seq_len = 4'd3;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("sa_busy", busy, 1'b0);
        @(negedge clk);
        chk("sa_busy2", busy, 1'b0);
        chk("sa_done", done, 1'b0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; seq_len = '0;
        player_en = 1'b0; player_press = 4'b0000;
        for (int i = 0; i < MAX_LEN; i++) mem[i] = 2'($urandom);
        repeat (3) @(negedge clk);
        chk("reset_led", led_color, 4'b0000);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_addr", rd_addr, 0);
        rst = 1'b0;

        mem[0] = 2'd0; mem[1] = 2'd3; mem[2] = 2'd1;
        play(3, 0, 1'b0, 1'b0);
        play(0, 0, 1'b0, 1'b0);
        for (int i = 0; i < MAX_LEN; i++) mem[i] = 2'd2;
        play(12, 0, 1'b0, 1'b0);
        mem[0] = 2'd0; mem[1] = 2'd3; mem[2] = 2'd1;
        play(3, 5, 1'b0, 1'b0);
        play(3, 0, 1'b0, 1'b0);

        echo_one(1'b1, 4'b0100);
        echo_one(1'b1, 4'b0110);
        echo_one(1'b0, 4'b0100);
        echo_one(1'b1, 4'b0000);

        play(3, 0, 1'b1, 1'b1);
        reset_mid_play();
        start_with_abort_idle();

        for (int n = 0; n < 14; n++) begin
            int req, ab;
            for (int i = 0; i < MAX_LEN; i++) mem[i] = 2'($urandom);
            req = $urandom_range(0, 12);
            ab  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 40) : 0;
            play(req, ab, 1'($urandom), 1'($urandom));
        end

        repeat (2) @(negedge clk);
        for (int n = 0; n < 20; n++) echo_one(1'($urandom), rand_press());

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
